arbiter_2_rr: RTL and testbench
===============================

ARBITER_2_RR -- requirements
Module: arbiter_2_rr

Interface
Parameters:
REQ-001 MAX_HOLD, 4, maximum consecutive grant cycles before a waiting requester preempts; legal range 2..16.
Ports:
REQ-002 Clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 Req_0  input  1  requester 0 asks for the shared write port; held high while it needs the port.
REQ-005 Req_1  input  1  requester 1 asks for the shared write port.
REQ-006 Grant_0  output  1  requester 0 owns the port this cycle.
REQ-007 Grant_1  output  1  requester 1 owns the port this cycle.
REQ-008 Enable  output  1  port owned by someone; drives the 1-of-2 decoder enable.
REQ-009 Sel  output  1  index of current owner; drives the 1-of-2 decoder select.
REQ-010 Preempt  output  1  one-cycle pulse in the first cycle after a hold-limit forced switch.

Function
REQ-011 States: IDLE, OWN0, OWN1; all outputs decoded from registered state only (Moore), no combinational Req-to-Grant path.
REQ-012 Latency: Req sampled at edge t; resulting Grant visible from t+1.
REQ-013 Enable = (state != IDLE); Sel = (state == OWN1); Grant_0 = Enable & ~Sel; Grant_1 = Enable & Sel; Grant_0 & Grant_1 never both 1.
REQ-014 Priority pointer Ptr (1 bit) selects winner when both request from IDLE; after any grant to n, Ptr = other index.
REQ-015 IDLE: no Req -> IDLE; one Req -> OWN of that requester; both -> OWN[Ptr].
REQ-016 OWNn, Req_n dropped: other requesting -> OWN[other] directly (no IDLE bubble); else -> IDLE.
REQ-017 Hold counter Hold counts grant cycles of current owner; cleared to 0 on every new grant (including direct switch).
REQ-018 OWNn, Req_n still high, Hold == MAX_HOLD-1, other requesting -> OWN[other], Preempt = 1 next cycle.
REQ-019 OWNn, Req_n high, Hold == MAX_HOLD-1, other idle -> stay OWNn, Hold wraps to 0, no Preempt.
REQ-020 Otherwise OWNn with Req_n high -> stay, Hold increments; Hold width = ceil(log2(MAX_HOLD)), never exceeds MAX_HOLD-1.
REQ-021 Simultaneous release by owner and new Req from same requester in same cycle: Req_n low wins; owner released per REQ-016.
REQ-022 Preempt pulses exactly one cycle; 0 in all other cycles.

Reset
REQ-023 Reset high at an edge: state = IDLE, Ptr = 0, Hold = 0, Preempt = 0 next cycle, regardless of Req or current ownership.
REQ-024 After reset output values: Grant_0 = Grant_1 = Enable = Sel = Preempt = 0.
REQ-025 Reset asserted mid-grant drops the grant at the next edge; Req sampled in the reset cycle is ignored.

Structure
REQ-026 Shared package holds state encoding constants (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and MAX_HOLD default.
REQ-027 One sub-module, arb_hold_counter: clear, increment, terminal-count flag at MAX_HOLD-1; FSM and Ptr stay in top level.

Verification
REQ-028 Reset, Req_0=1 only -> Grant_0=1, Sel=0, Enable=1 from next cycle; holds indefinitely (Hold wraps, Preempt stays 0).
REQ-029 From IDLE with Ptr=0, Req_0=Req_1=1 same edge -> Grant_0 for 4 cycles, then Grant_1 with Preempt=1 for one cycle; Grant_1 4 cycles, then Grant_0 again.
REQ-030 OWN0 at Hold=1, Req_0 drops while Req_1=1 -> Grant_1 next cycle, no IDLE cycle, Preempt=0, Hold=0.
REQ-031 OWN1, Req_1 drops, Req_0=0 -> IDLE next cycle; then both request -> Grant_0 (Ptr=0).
REQ-032 Reset pulsed while Grant_1=1 and both requesting -> all outputs 0 next cycle; after Reset low, Grant_0 wins (Ptr=0).
REQ-033 Random Req streams, 10k cycles: assert Grant mutual exclusion, no grant without prior-cycle Req, no requester waits > MAX_HOLD+1 cycles while continuously requesting.

Source files
------------

// File: rtl/arbiter_2_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arbiter_2_rr_pkg
// Purpose : State encoding and default hold limit shared by the 2-way arbiter.
// Revision: 1.0
// ============================================================================
package arbiter_2_rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int c_max_hold_default = 4;

endpackage
`default_nettype wire

// File: rtl/arb_hold_counter.sv
`default_nettype none
// ============================================================================
// Module  : arb_hold_counter
// Purpose : Counts grant cycles of the current owner; flags MAX_HOLD-1.
// Revision: 1.0
// ============================================================================
module arb_hold_counter #(
  parameter int MAX_HOLD = 4,
  parameter int W        = $clog2(MAX_HOLD)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_terminal
);

  localparam logic [W-1:0] c_term = W'(MAX_HOLD - 1);
  localparam logic [W-1:0] c_one  = W'(1);

  logic [W-1:0] r_count;

  // An uncontested owner keeps the port, so the count simply wraps at the limit.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= (r_count == c_term) ? '0 : r_count + c_one;
    end
  end

  assign o_terminal = (r_count == c_term);

endmodule
`default_nettype wire

// File: rtl/arbiter_2_rr.sv
`default_nettype none
// ============================================================================
// Module  : arbiter_2_rr
// Purpose : Two-requester round-robin arbiter with hold-limit preemption.
// Revision: 1.0
// ============================================================================
module arbiter_2_rr
  import arbiter_2_rr_pkg::*;
#(
  parameter int MAX_HOLD = c_max_hold_default
) (
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic grant_0,
  output logic grant_1,
  output logic enable,
  output logic sel,
  output logic preempt
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_ptr;
  logic       r_grant_0;
  logic       r_grant_1;
  logic       r_enable;
  logic       r_sel;
  logic       r_preempt;
  logic       w_clear;
  logic       w_inc;
  logic       w_preempt;
  logic       w_term;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk        (clock),
    .rst        (reset),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .o_terminal (w_term)
  );

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_inc     = 1'b0;
    w_preempt = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (req_0 && req_1) w_next = r_ptr ? OWN1 : OWN0;
        else if (req_0)     w_next = OWN0;
        else if (req_1)     w_next = OWN1;
      end
      OWN0: begin
        if (!req_0) begin
          w_clear = 1'b1;
          w_next  = req_1 ? OWN1 : IDLE;
        end else if (w_term && req_1) begin
          w_clear   = 1'b1;
          w_next    = OWN1;
          w_preempt = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      OWN1: begin
        if (!req_1) begin
          w_clear = 1'b1;
          w_next  = req_0 ? OWN0 : IDLE;
        end else if (w_term && req_0) begin
          w_clear   = 1'b1;
          w_next    = OWN0;
          w_preempt = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: begin
        w_clear = 1'b1;
        w_next  = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_grant_0 <= 1'b0;
      r_grant_1 <= 1'b0;
      r_enable  <= 1'b0;
      r_sel     <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_preempt <= w_preempt;
      r_grant_0 <= (w_next == OWN0);
      r_grant_1 <= (w_next == OWN1);
      r_enable  <= (w_next != IDLE);
      r_sel     <= (w_next == OWN1);
      if (w_next == OWN0)      r_ptr <= 1'b1;
      else if (w_next == OWN1) r_ptr <= 1'b0;
    end
  end

  assign grant_0 = r_grant_0;
  assign grant_1 = r_grant_1;
  assign enable  = r_enable;
  assign sel     = r_sel;
  assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_2_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_arbiter_2_rr
// Purpose : Directed and random checks of arbiter_2_rr against an owner model.
// Revision: 1.0
// ============================================================================
module tb_arbiter_2_rr;

  localparam int MAX_HOLD = 4;

  logic clock = 1'b0;
  logic reset;
  logic req_0;
  logic req_1;
  logic grant_0;
  logic grant_1;
  logic enable;
  logic sel;
  logic preempt;

  int   n_vec  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  // Model: who owns the port, how many cycles they have owned it, who wins a tie.
  int   m_owner = -1;
  int   m_run   = 0;
  int   m_ptr   = 0;
  int   m_nxt;
  bit   m_pre   = 1'b0;
  bit   m_p;
  logic s_rst   = 1'b1;
  logic s_r [2];
  int   w0 = 0;
  int   w1 = 0;

  arbiter_2_rr #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req_0   (req_0),
    .req_1   (req_1),
    .grant_0 (grant_0),
    .grant_1 (grant_1),
    .enable  (enable),
    .sel     (sel),
    .preempt (preempt)
  );

  always #5 clock = ~clock;

  task automatic check(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    s_rst  = reset;
    s_r[0] = req_0;
    s_r[1] = req_1;
    m_p    = 1'b0;
    m_nxt  = m_owner;
    if (reset) begin
      m_nxt = -1;
      m_ptr = 0;
      m_run = 0;
    end else if (m_owner < 0) begin
      if (req_0 && req_1) m_nxt = m_ptr;
      else if (req_0)     m_nxt = 0;
      else if (req_1)     m_nxt = 1;
    end else if (!s_r[m_owner]) begin
      m_nxt = s_r[1-m_owner] ? 1 - m_owner : -1;
    end else if (m_run == MAX_HOLD && s_r[1-m_owner]) begin
      m_nxt = 1 - m_owner;
      m_p   = 1'b1;
    end
    if (!reset) begin
      if (m_nxt >= 0 && m_nxt != m_owner) begin
        m_run = 1;
        m_ptr = 1 - m_nxt;
      end else if (m_nxt >= 0) begin
        m_run = (m_run == MAX_HOLD) ? 1 : m_run + 1;
      end else begin
        m_run = 0;
      end
    end
    m_owner = m_nxt;
    m_pre   = m_p;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("outputs_vs_model", int'({grant_0, grant_1, enable, sel, preempt}),
            int'({m_owner == 0, m_owner == 1, m_owner >= 0, m_owner == 1, m_pre}));
      check("mutex", int'(grant_0 & grant_1), 0);
      check("grant0_without_req", int'(grant_0 & ~(s_r[0] & ~s_rst)), 0);
      check("grant1_without_req", int'(grant_1 & ~(s_r[1] & ~s_rst)), 0);
      w0 = (s_rst || !s_r[0] || grant_0) ? 0 : w0 + 1;
      w1 = (s_rst || !s_r[1] || grant_1) ? 0 : w1 + 1;
      check("wait0_bound", (w0 > MAX_HOLD + 1) ? w0 : 0, 0);
      check("wait1_bound", (w1 > MAX_HOLD + 1) ? w1 : 0, 0);
    end
  end

  task automatic cyc(input logic r, input logic a, input logic b);
    reset = r;
    req_0 = a;
    req_1 = b;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Literal expectation for both the DUT outputs and the model's owner state.
  task automatic lit(string name, bit g0, bit g1, bit pre);
    check(name, int'({grant_0, grant_1, enable, sel, preempt}),
          int'({g0, g1, g0 | g1, g1, pre}));
    check({name, "_model"}, m_owner, g0 ? 0 : (g1 ? 1 : -1));
  endtask

  initial begin
    logic a;
    logic b;
    logic r;
    reset = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    @(negedge clock);
    cyc(1, 1, 1);
    chk_en = 1'b1;
    lit("reset_state", 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0);
      lit("solo_req0", 1, 0, 0);
    end

    cyc(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1);
      lit("both_round_robin", ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, (i % 4 == 0) && (i > 0));
    end

    cyc(1, 0, 0);
    cyc(0, 1, 0);
    lit("own0_first", 1, 0, 0);
    cyc(0, 1, 1);
    lit("own0_hold1", 1, 0, 0);
    cyc(0, 0, 1);
    lit("drop_direct_switch", 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1);
      lit("own1_after_switch", 0, 1, 0);
    end
    cyc(0, 1, 1);
    lit("preempt_back_to0", 1, 0, 1);
    cyc(0, 0, 1);
    lit("release_to1", 0, 1, 0);
    cyc(0, 0, 0);
    lit("release_to_idle", 0, 0, 0);
    cyc(0, 1, 1);
    lit("idle_tie_ptr0", 1, 0, 0);

    cyc(1, 0, 0);
    cyc(0, 0, 1);
    lit("own1_before_reset", 0, 1, 0);
    cyc(0, 1, 1);
    lit("own1_both_req", 0, 1, 0);
    cyc(1, 1, 1);
    lit("reset_mid_grant", 0, 0, 0);
    cyc(0, 1, 1);
    lit("after_reset_tie", 1, 0, 0);

    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(3) == 0) b = ~b;
      r = ($urandom_range(299) == 0);
      cyc(r, a, b);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
